// File: rtl/eq_sweep_sequencer.sv
// Purpose: drives a shared pattern into an original and a revised logic cone and compares their outputs.
// Latency: one pattern per cycle; the compare result is registered one cycle after its pattern.
// Backpressure: none; start is ignored while busy, and abort or rst ends a run at the next edge.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, abort      launch a run (only from IDLE/DONE) / drop back to IDLE
//   mode              0 = exhaustive counter, 1 = LFSR (latched at start)
//   stop_on_fail      end the run at the first registered mismatch (latched at start)
//   seed, limit       LFSR seed and pattern count minus 1 (latched at start)
//   pat               registered vector feeding both cones
//   ref_o, rev_o      cone outputs for the current pat
//   busy, done        RUN/DRAIN and DONE indicators
//   fail, fail_pat    sticky mismatch flag and the pattern of the first mismatch
//   checked           patterns compared in the current run (W+1 bits so a full sweep does not wrap)
module eq_sweep_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         mode,
    input  logic         stop_on_fail,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] limit,
    output logic [W-1:0] pat,
    input  logic         ref_o,
    input  logic         rev_o,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [W-1:0] fail_pat,
    output logic [W:0]   checked
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_W1 = {{W{1'b0}}, 1'b1};

    logic [1:0]   state;
    logic         mode_q;
    logic         sof_q;
    logic [W-1:0] limit_q;
    logic [W-1:0] issued;

    // Compare stage: mismatch flag and the pattern it belongs to.
    logic         cmp_vld;
    logic         cmp_mis;
    logic [W-1:0] cmp_pat;

    logic [W-1:0] first_pat;
    logic [W-1:0] next_pat;
    logic         cmp_hit;

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    assign first_pat = mode ? ((seed == '0) ? ONE_W : seed) : '0;
    assign next_pat  = mode_q ? {pat[W-2:0], pat[W-1] ^ pat[W-3] ^ pat[W-4] ^ pat[W-6]}
                              : pat + ONE_W;
    assign cmp_hit   = cmp_vld & cmp_mis;

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            sof_q    <= 1'b0;
            limit_q  <= '0;
            issued   <= '0;
            pat      <= '0;
            cmp_vld  <= 1'b0;
            cmp_mis  <= 1'b0;
            cmp_pat  <= '0;
            fail     <= 1'b0;
            fail_pat <= '0;
            checked  <= '0;
        end else if (abort) begin
            // Results stay as they were; the pending compare is dropped.
            state   <= S_IDLE;
            cmp_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RUN;
                        mode_q   <= mode;
                        sof_q    <= stop_on_fail;
                        limit_q  <= limit;
                        issued   <= '0;
                        pat      <= first_pat;
                        cmp_vld  <= 1'b0;
                        fail     <= 1'b0;
                        fail_pat <= '0;
                        checked  <= '0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (cmp_vld) begin
                        checked <= checked + ONE_W1;
                        if (cmp_mis && !fail) begin
                            fail     <= 1'b1;
                            fail_pat <= cmp_pat;
                        end
                    end
                    if (cmp_hit && sof_q) begin
                        // The pattern currently on pat is in flight and never counted.
                        state   <= S_DONE;
                        cmp_vld <= 1'b0;
                    end else if (state == S_RUN) begin
                        cmp_vld <= 1'b1;
                        cmp_mis <= (ref_o != rev_o);
                        cmp_pat <= pat;
                        issued  <= issued + ONE_W;
                        if (issued == limit_q) begin
                            state <= S_DRAIN;
                        end else begin
                            pat <= next_pat;
                        end
                    end else begin
                        // DRAIN: the last pattern's compare is absorbed this cycle.
                        cmp_vld <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/eq_sweep_sequencer.md
EQ_SWEEP_SEQUENCER -- requirements
Module: eq_sweep_sequencer

Interface
REQ-001 Parameter: W, default 16, width of the primary-input vector applied to the cones under test.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  launch request; sampled only in IDLE or DONE.
REQ-005 Port: abort  input  1  terminate a run; return to IDLE.
REQ-006 Port: mode  input  1  pattern source: 0 = exhaustive counter, 1 = LFSR; sampled at start.
REQ-007 Port: stop_on_fail  input  1  1 = end the run at the first mismatch; sampled at start.
REQ-008 Port: seed  input  W  LFSR seed; sampled at start.
REQ-009 Port: limit  input  W  pattern count minus 1; sampled at start.
REQ-010 Port: pat  output  W  registered vector driving the inputs of both the original cone and the revised cone.
REQ-011 Port: ref_o  input  1  combinational output of the original cone for the current pat.
REQ-012 Port: rev_o  input  1  combinational output of the revised cone for the current pat.
REQ-013 Port: busy  output  1  high in RUN and DRAIN.
REQ-014 Port: done  output  1  high in DONE.
REQ-015 Port: fail  output  1  sticky; at least one mismatch in the current run.
REQ-016 Port: fail_pat  output  W  pat value of the first mismatch.
REQ-017 Port: checked  output  W+1  number of compared patterns in the current run.

Function
REQ-018 States: IDLE, RUN, DRAIN, DONE; the state and every output register SHALL be updated only on the rising edge of clk.
REQ-019 IDLE/DONE with start=1 and abort=0 -> RUN; latch mode, stop_on_fail, seed and limit; clear fail, fail_pat and checked; load pat with the first pattern.
REQ-020 First pattern: mode 0 -> 0; mode 1 -> seed, or 16'h0001 (generally 1) when seed==0.
REQ-021 Successor pattern: mode 0 -> pat+1; mode 1 -> {pat[W-2:0], pat[15]^pat[13]^pat[12]^pat[10]} (W=16 taps).
REQ-022 RUN issues exactly limit+1 patterns, one per cycle; after issuing the last pattern -> DRAIN, with pat holding its value.
REQ-023 Compare stage, one cycle of latency: each cycle in RUN or DRAIN, register (ref_o != rev_o) together with the current pat; a registered compare for a valid pattern increments checked.
REQ-024 On the first registered mismatch: set fail, and capture the paired pat into fail_pat; later mismatches SHALL NOT change fail_pat.
REQ-025 stop_on_fail=1 and a registered mismatch -> DONE next cycle; in-flight patterns are discarded and do not increment checked.
REQ-026 DRAIN lasts one cycle so that the compare result of the last pattern is captured, then -> DONE.
REQ-027 DONE holds done, fail, fail_pat and checked stable until the next accepted start.
REQ-028 abort=1 in any state -> IDLE next cycle; done=0; fail, fail_pat and checked keep their last values; abort overrides a simultaneous start.
REQ-029 start in RUN or DRAIN SHALL be ignored.
REQ-030 limit = all-ones in mode 0 SHALL sweep the full 2^W space; checked reaches 2^W without wrap, which is why it is W+1 bits wide.

Reset
REQ-031 rst=1 at any clock edge -> IDLE; pat=0, busy=0, done=0, fail=0, fail_pat=0, checked=0; pending compare discarded; rst overrides start and abort.

Verification
REQ-032 rev_o tied to ref_o, mode 0, limit=16'hFFFF -> done after 65538 cycles, fail=0, checked=17'h10000.
REQ-033 rev_o = ref_o ^ (pat==16'h1234), mode 0, limit=16'hFFFF, stop_on_fail=1 -> done, fail=1, fail_pat=16'h1234, checked=17'h01235.
REQ-034 Same stimulus as REQ-033 with stop_on_fail=0 -> full sweep, fail=1, fail_pat=16'h1234, checked=17'h10000.
REQ-035 mode 1, seed=0, limit=3 -> pat sequence 0001, 0002, 0004, 0008; then DRAIN, then DONE with checked=4.
REQ-036 abort asserted at the 10th cycle of RUN -> next cycle IDLE, busy=0, done=0; start asserted in the same cycle as abort is ignored.
REQ-037 rst pulsed mid-run -> all outputs 0 next cycle; a following start runs normally from the first pattern.
